// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared configuration for the board-switch input conditioner that feeds the
// APB GPIO block. Holds the default channel count, synchronizer depth and
// debounce counter sizing. It also holds a helper that tells whether a
// stability target fits its counter.
// -----------------------------------------------------------------------------
package gpio_pkg;

    localparam int GPIO_WIDTH           = 16;
    localparam int GPIO_SYNC_STAGES     = 2;
    localparam int GPIO_DEBOUNCE_CYCLES = 1000000;
    localparam int GPIO_DEBOUNCE_CNT_W  = 20;

    // True when 1 <= cycles < 2**cnt_w. The shift form avoids 32-bit overflow
    // of 2**cnt_w for wide counters.
    function automatic bit debounce_cfg_ok(input int cycles, input int cnt_w);
        return (cycles >= 1) && ((64'(cycles) >> cnt_w) == 64'd0);
    endfunction

endpackage : gpio_pkg

// File: rtl/gpio_debounce_bit.sv
// -----------------------------------------------------------------------------
// gpio_debounce_bit
// One switch channel. It contains a SYNC_STAGES-deep synchronizer, a stability
// counter, the debounced level flop and the one-cycle edge pulses.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-low reset
//   sw_raw     in   raw switch pin, asynchronous to clock
//   sw_stable  out  debounced level
//   sw_rise    out  one-cycle pulse on the first cycle sw_stable shows 1
//   sw_fall    out  one-cycle pulse on the first cycle sw_stable shows 0
// -----------------------------------------------------------------------------
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
    parameter int CNT_W         = GPIO_DEBOUNCE_CNT_W,
    parameter int STABLE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_stable,
    output logic sw_rise,
    output logic sw_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync_bit;
    logic                   differ;
    logic                   accept;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign differ   = sync_bit ^ sw_stable;
    // The counter stops at CNT_LAST. The accepting edge returns it to 0, so
    // it needs no wrap or saturation logic.
    assign accept   = differ && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sw_stable <= 1'b0;
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
        end else begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                // The pulse lands on the same edge as the new level.
                sw_stable <= sync_bit;
                sw_rise   <= sync_bit;
                sw_fall   <= ~sync_bit;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : gpio_debounce_bit

// File: rtl/gpio_switch_debounce.sv
// -----------------------------------------------------------------------------
// gpio_switch_debounce
// Conditions the raw board switches for the APB GPIO block. Each channel is
// synchronized and debounced independently. Each channel also exports
// one-cycle rise and fall pulses.
//
// Optional feature, enabled by the macro GPIO_DEBOUNCE_EVENT_EN:
//   sticky per-bit event flags (evt_pending) with write-one-to-clear acks.
//   It also adds a registered irq, which is the OR of the flags.
//   Without the macro the ports remain, evt_pending and irq read 0, and
//   evt_ack is ignored.
//
// Ports:
//   clock        in   system clock
//   reset        in   asynchronous, active-low reset
//   sw_raw       in   [WIDTH] raw switch pins, asynchronous to clock
//   sw_stable    out  [WIDTH] debounced levels, drives GPIO gpio_in
//   sw_rise      out  [WIDTH] one-cycle pulse on sw_stable 0->1
//   sw_fall      out  [WIDTH] one-cycle pulse on sw_stable 1->0
//   evt_ack      in   [WIDTH] write-one-to-clear for evt_pending
//   evt_pending  out  [WIDTH] sticky edge-event flags
//   irq          out  OR of evt_pending, one cycle late
// -----------------------------------------------------------------------------
module gpio_switch_debounce
    import gpio_pkg::*;
#(
    parameter int WIDTH         = GPIO_WIDTH,
    parameter int SYNC_STAGES   = GPIO_SYNC_STAGES,
    parameter int CNT_W         = GPIO_DEBOUNCE_CNT_W,
    parameter int STABLE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    input  logic [WIDTH-1:0] evt_ack,
    output logic [WIDTH-1:0] evt_pending,
    output logic             irq
);

    if (!debounce_cfg_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_stable_cycles
        $error("gpio_switch_debounce: STABLE_CYCLES must satisfy 1 <= STABLE_CYCLES < 2**CNT_W");
    end

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
        $error("gpio_switch_debounce: SYNC_STAGES must be 2 or 3");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        gpio_debounce_bit #(
            .SYNC_STAGES  (SYNC_STAGES),
            .CNT_W        (CNT_W),
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clock    (clock),
            .reset    (reset),
            .sw_raw   (sw_raw[i]),
            .sw_stable(sw_stable[i]),
            .sw_rise  (sw_rise[i]),
            .sw_fall  (sw_fall[i])
        );
    end

`ifdef GPIO_DEBOUNCE_EVENT_EN
    // A new edge beats an ack on the same bit in the same cycle. This means
    // an event is never lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            evt_pending <= '0;
            irq         <= 1'b0;
        end else begin
            evt_pending <= (evt_pending & ~evt_ack) | sw_rise | sw_fall;
            irq         <= |evt_pending;
        end
    end
`else
    logic unused_evt_ack;

    assign evt_pending    = '0;
    assign irq            = 1'b0;
    assign unused_evt_ack = ^evt_ack;
`endif

endmodule : gpio_switch_debounce
